// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing the data_mem port between the LSU (port 0)
// and a DMA/debug loader (port 1); misaligned or out-of-range accesses never reach memory.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_signed,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_signed,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic        is_signed,
  output logic [31:0] addr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        port_q, port_d;
  logic        p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

  logic        win_s, gnt0_s, gnt1_s;
  logic        sel_we_s, sel_signed_s, sel_err_s;
  logic [1:0]  sel_size_s;
  logic [31:0] sel_addr_s, sel_wdata_s;
  logic [2:0]  bytes_s;
  logic [32:0] end_s;

  // Winner selection and request validation; the 33-bit end address cannot wrap.
  always_comb begin
    if (p0_req && p1_req) begin
      win_s = ~last_q;
    end else begin
      win_s = p1_req;
    end
    sel_we_s     = win_s ? p1_we     : p0_we;
    sel_size_s   = win_s ? p1_size   : p0_size;
    sel_signed_s = win_s ? p1_signed : p0_signed;
    sel_addr_s   = win_s ? p1_addr   : p0_addr;
    sel_wdata_s  = win_s ? p1_wdata  : p0_wdata;
    case (sel_size_s)
      2'b00:   bytes_s = 3'd1;
      2'b01:   bytes_s = 3'd2;
      default: bytes_s = 3'd4;
    endcase
    end_s = {1'b0, sel_addr_s} + {30'd0, bytes_s};
    sel_err_s = (sel_size_s == 2'b11)
             || ((sel_size_s == 2'b01) && sel_addr_s[0])
             || ((sel_size_s == 2'b10) && (sel_addr_s[1:0] != 2'b00))
             || (end_s > 33'(MEM_BYTES));
  end

  // Sequencer next-state, request latch and per-port response capture.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    we_d       = we_q;
    size_d     = size_q;
    signed_d   = signed_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    port_d     = port_q;
    p0_err_d   = p0_err_q;
    p1_err_d   = p1_err_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          gnt0_s   = ~win_s;
          gnt1_s   = win_s;
          last_d   = win_s;
          we_d     = sel_we_s;
          size_d   = sel_size_s;
          signed_d = sel_signed_s;
          addr_d   = sel_addr_s;
          wdata_d  = sel_wdata_s;
          port_d   = win_s;
          if (sel_err_s) begin
            state_d = DONE;
            if (win_s) begin
              p1_err_d   = 1'b1;
              p1_rdata_d = 32'd0;
            end else begin
              p0_err_d   = 1'b1;
              p0_rdata_d = 32'd0;
            end
          end else begin
            state_d = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (port_q) begin
          p1_err_d   = 1'b0;
          p1_rdata_d = we_q ? 32'd0 : read_data;
        end else begin
          p0_err_d   = 1'b0;
          p0_rdata_d = we_q ? 32'd0 : read_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      port_q     <= 1'b0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
      p0_rdata_q <= 32'd0;
      p1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      we_q       <= we_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      port_q     <= port_d;
      p0_err_q   <= p0_err_d;
      p1_err_q   <= p1_err_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // Grants are combinational, so they are masked while reset is held.
  assign p0_gnt     = gnt0_s & ~rst;
  assign p1_gnt     = gnt1_s & ~rst;
  assign p0_rvalid  = (state_q == DONE) && !port_q;
  assign p1_rvalid  = (state_q == DONE) && port_q;
  assign p0_err     = p0_err_q;
  assign p1_err     = p1_err_q;
  assign p0_rdata   = p0_rdata_q;
  assign p1_rdata   = p1_rdata_q;
  assign mem_read   = (state_q == ACCESS) && !we_q;
  assign mem_write  = (state_q == ACCESS) && we_q;
  assign mem_size   = size_q;
  assign is_signed  = signed_q;
  assign addr       = addr_q;
  assign write_data = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1 KiB data_mem model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_signed, p0_gnt, p0_rvalid, p0_err;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_signed, p1_gnt, p1_rvalid, p1_err;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_read, mem_write, is_signed;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, read_data;

  logic [7:0]  mem [0:1023];
  logic        clr_mem;
  logic [9:0]  a0, a1, a2, a3;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_signed(p0_signed),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_signed(p1_signed),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .is_signed(is_signed), .addr(mem_addr), .write_data(mem_wdata),
    .read_data(read_data)
  );

  assign a0 = mem_addr[9:0];
  assign a1 = a0 + 10'd1;
  assign a2 = a0 + 10'd2;
  assign a3 = a0 + 10'd3;

  // Little-endian data memory: combinational read with sign extension.
  always_comb begin
    case (mem_size)
      2'b00:   read_data = {{24{is_signed & mem[a0][7]}}, mem[a0]};
      2'b01:   read_data = {{16{is_signed & mem[a1][7]}}, mem[a1], mem[a0]};
      default: read_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  // Store port of the memory model, plus a one-time clear at start-up.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      mem[a0] <= mem_wdata[7:0];
      if (mem_size != 2'b00) mem[a1] <= mem_wdata[15:8];
      if (mem_size == 2'b10) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access from IDLE: grant, optional memory cycle, response; returns in IDLE.
  task automatic do_acc(input string tag, input bit port, input bit we, input logic [1:0] size,
                        input bit sgn, input logic [31:0] a, input logic [31:0] wd,
                        input bit exp_err, input logic [31:0] exp_rd);
    @(negedge clk);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_size = size; p1_signed = sgn; p1_addr = a; p1_wdata = wd;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_size = size; p0_signed = sgn; p0_addr = a; p0_wdata = wd;
    end
    #1;
    chk({tag, ".gnt"}, {31'd0, port ? p1_gnt : p0_gnt}, 32'd1);
    chk({tag, ".gnt_other"}, {31'd0, port ? p0_gnt : p1_gnt}, 32'd0);
    @(posedge clk); #1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    if (!exp_err) begin
      chk({tag, ".mem_read"}, {31'd0, mem_read}, {31'd0, !we});
      chk({tag, ".mem_write"}, {31'd0, mem_write}, {31'd0, we});
      chk({tag, ".addr"}, mem_addr, a);
      @(posedge clk); #1;
    end else begin
      chk({tag, ".strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
    end
    chk({tag, ".rvalid"}, {31'd0, port ? p1_rvalid : p0_rvalid}, 32'd1);
    chk({tag, ".rvalid_other"}, {31'd0, port ? p0_rvalid : p1_rvalid}, 32'd0);
    chk({tag, ".err"}, {31'd0, port ? p1_err : p0_err}, {31'd0, exp_err});
    chk({tag, ".rdata"}, port ? p1_rdata : p0_rdata, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; clr_mem = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_size = 2'b10; p0_signed = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0;
    p1_req = 1'b1; p1_we = 1'b0; p1_size = 2'b10; p1_signed = 1'b0; p1_addr = 32'd4; p1_wdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst.outs", {26'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_read, mem_write}, 32'd0);
      chk("rst.rdata", p0_rdata | p1_rdata, 32'd0);
    end
    clr_mem = 1'b0;

    // Both ports request continuously: grants alternate every 3 cycles, port 0 first.
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("rr.c%0d", c), {28'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid},
          {28'd0, (c % 6) == 0, (c % 6) == 3, (c % 6) == 2, (c % 6) == 5});
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(posedge clk); #1;

    do_acc("sb10",   1'b0, 1'b1, 2'b00, 1'b0, 32'd10,  32'h000000AA, 1'b0, 32'h0);
    do_acc("lb10",   1'b0, 1'b0, 2'b00, 1'b1, 32'd10,  32'h0,        1'b0, 32'hFFFFFFAA);
    do_acc("lbu10",  1'b0, 1'b0, 2'b00, 1'b0, 32'd10,  32'h0,        1'b0, 32'h000000AA);
    do_acc("p1sw",   1'b1, 1'b1, 2'b10, 1'b0, 32'd100, 32'hDEADBEEF, 1'b0, 32'h0);
    do_acc("lh100",  1'b0, 1'b0, 2'b01, 1'b1, 32'd100, 32'h0,        1'b0, 32'hFFFFBEEF);
    do_acc("lhu102", 1'b0, 1'b0, 2'b01, 1'b0, 32'd102, 32'h0,        1'b0, 32'h0000DEAD);

    do_acc("e_lh21",   1'b0, 1'b0, 2'b01, 1'b1, 32'd21,   32'h0,        1'b1, 32'h0);
    do_acc("e_sw102",  1'b0, 1'b1, 2'b10, 1'b0, 32'd102,  32'h11111111, 1'b1, 32'h0);
    do_acc("e_size3",  1'b0, 1'b1, 2'b11, 1'b0, 32'd100,  32'h22222222, 1'b1, 32'h0);
    do_acc("e_sw1022", 1'b0, 1'b1, 2'b10, 1'b0, 32'd1022, 32'h33333333, 1'b1, 32'h0);
    do_acc("e_top",    1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0,    1'b1, 32'h0);
    do_acc("ok_1020",  1'b1, 1'b0, 2'b10, 1'b0, 32'd1020, 32'h0,        1'b0, 32'h0);

    do_acc("sw200",  1'b0, 1'b1, 2'b10, 1'b0, 32'd200, 32'hCAFEF00D, 1'b0, 32'h0);
    do_acc("lw100",  1'b0, 1'b0, 2'b10, 1'b0, 32'd100, 32'h0,        1'b0, 32'hDEADBEEF);

    // Store to 200 aborted by reset during its memory cycle.
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b1; p0_size = 2'b10; p0_addr = 32'd200; p0_wdata = 32'h12345678;
    #1;
    chk("abort.gnt", {31'd0, p0_gnt}, 32'd1);
    @(posedge clk); #1;
    p0_req = 1'b0;
    chk("abort.mem_write_on", {31'd0, mem_write}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort.mem_write_off", {31'd0, mem_write}, 32'd0);
    @(posedge clk); #1;
    chk("abort.rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    chk("abort.rdata_zero", p0_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort.no_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    do_acc("lw200", 1'b0, 1'b0, 2'b10, 1'b0, 32'd200, 32'h0, 1'b0, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
